// File: rtl/prio_scan_encoder.sv
// MSB-first priority scan: accepts a request vector and emits one beat per set bit, highest index first.
// Optional PRIO_SCAN_CNT_EN adds out_cnt, the number of bits still pending including the current beat.
module prio_scan_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         out_empty
`ifdef PRIO_SCAN_CNT_EN
  ,
  output logic [W:0]   out_cnt
`endif
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   hi_idx;
  logic [W:0]     pop;

  // Highest set bit and population count of the pending vector.
  always_comb begin
    hi_idx = '0;
    pop    = '0;
    for (int unsigned i = 0; i < unsigned'(N); i++) begin
      if (pending_q[i]) begin
        hi_idx = i[W-1:0];
        pop    = pop + (W+1)'(1);
      end
    end
  end

  // Outputs come only from state_q/pending_q; an empty beat is EMIT with nothing pending.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == EMIT);
    out_idx   = out_valid ? hi_idx : '0;
    out_empty = out_valid && (pending_q == '0);
    out_last  = out_valid && (pop <= (W+1)'(1));
  end

`ifdef PRIO_SCAN_CNT_EN
  always_comb begin
    out_cnt = out_valid ? pop : '0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_data;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d[hi_idx] = 1'b0;
          if (out_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Self-checking bench for prio_scan_encoder: table vectors, model-checked random scans, reset and back-to-back corners.
module tb_prio_scan_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // N=8 instance
  logic [7:0] in_data8;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_empty8;
  logic [2:0] out_idx8;
  // N=16 instance
  logic [15:0] in_data16;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, out_empty16;
  logic [3:0]  out_idx16;
`ifdef PRIO_SCAN_CNT_EN
  logic [3:0]  out_cnt8;
  logic [4:0]  out_cnt16;
`endif

  prio_scan_encoder #(.N(8), .W(3)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_idx(out_idx8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_last(out_last8), .out_empty(out_empty8)
`ifdef PRIO_SCAN_CNT_EN
    , .out_cnt(out_cnt8)
`endif
  );

  prio_scan_encoder #(.N(16), .W(4)) dut16 (
    .clk(clk), .rst(rst), .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out_idx(out_idx16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_last(out_last16), .out_empty(out_empty16)
`ifdef PRIO_SCAN_CNT_EN
    , .out_cnt(out_cnt16)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready held high; 1: toggling starting with a stall; 2: random ready plus in_valid noise
  task automatic scan8(input logic [7:0] vec, input int mode, input string tag);
    int exp_q[$];
    int beat, cyc;
    bit rdy, stalled;
    logic [2:0] p_idx;
    logic p_last, p_empty;
    for (int i = 7; i >= 0; i--)
      if (((vec >> i) & 8'd1) != 8'd0) exp_q.push_back(i);
    if (exp_q.size() == 0) exp_q.push_back(0);

    cyc = 0;
    while (!in_ready8 && cyc < 50) begin tick(); cyc++; end
    check({tag, "_ready_before"}, in_ready8, 1);
    in_data8 = vec; in_valid8 = 1'b1; out_ready8 = 1'b0;
    tick();
    in_valid8 = 1'b0; in_data8 = 8'($urandom);

    beat = 0; cyc = 0; stalled = 1'b0;
    p_idx = '0; p_last = 1'b0; p_empty = 1'b0;
    while (beat < exp_q.size() && cyc < 200) begin
      check({tag, "_valid"}, out_valid8, 1);
      if (out_valid8 !== 1'b1) break;
      if (stalled) begin
        check({tag, "_hold_idx"}, out_idx8, p_idx);
        check({tag, "_hold_last"}, out_last8, p_last);
        check({tag, "_hold_empty"}, out_empty8, p_empty);
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      out_ready8 = rdy;
      if (mode == 2) begin
        in_valid8 = 1'($urandom_range(0, 1));
        in_data8  = 8'($urandom);
      end
      if (rdy) begin
        check({tag, "_idx"}, out_idx8, exp_q[beat]);
        check({tag, "_last"}, out_last8, (beat == exp_q.size() - 1));
        check({tag, "_empty"}, out_empty8, (vec == 8'd0));
`ifdef PRIO_SCAN_CNT_EN
        check({tag, "_cnt"}, out_cnt8, (vec == 8'd0) ? 0 : exp_q.size() - beat);
`endif
        if (beat == exp_q.size() - 1) in_valid8 = 1'b0;
        beat++;
      end
      stalled = !rdy;
      p_idx = out_idx8; p_last = out_last8; p_empty = out_empty8;
      tick();
      cyc++;
    end
    out_ready8 = 1'b0;
    in_valid8  = 1'b0;
    check({tag, "_beats"}, beat, exp_q.size());
    check({tag, "_idle_ready"}, in_ready8, 1);
    check({tag, "_idle_valid"}, out_valid8, 0);
  endtask

  typedef struct {
    logic [7:0]  data;
    int          nbeats;
    logic [31:0] idxs;   // expected indices, first beat in the top nibble
    logic        empty;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'b10100011, 4, 32'h7510_0000, 1'b0};
    tbl[1] = '{8'b00000000, 1, 32'h0000_0000, 1'b1};
    tbl[2] = '{8'b11111111, 8, 32'h7654_3210, 1'b0};
    tbl[3] = '{8'b00000001, 1, 32'h0000_0000, 1'b0};
    tbl[4] = '{8'b10000000, 1, 32'h7000_0000, 1'b0};
    tbl[5] = '{8'b00100100, 2, 32'h5200_0000, 1'b0};

    rst = 1'b1;
    in_data8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    in_data16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    #1;
    check("rst_in_ready", in_ready8, 1);
    check("rst_out_valid", out_valid8, 0);
    check("rst_out_idx", out_idx8, 0);
    check("rst_out_last", out_last8, 0);
    check("rst_out_empty", out_empty8, 0);
    check("rst16_in_ready", in_ready16, 1);
`ifdef PRIO_SCAN_CNT_EN
    check("rst_out_cnt", out_cnt8, 0);
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    // Table vectors with out_ready held high
    foreach (tbl[e]) begin
      check("tbl_ready", in_ready8, 1);
      in_data8 = tbl[e].data; in_valid8 = 1'b1; out_ready8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      for (int b = 0; b < tbl[e].nbeats; b++) begin
        check("tbl_valid", out_valid8, 1);
        check("tbl_idx", out_idx8, tbl[e].idxs[31-4*b -: 4]);
        check("tbl_last", out_last8, (b == tbl[e].nbeats - 1));
        check("tbl_empty", out_empty8, tbl[e].empty);
`ifdef PRIO_SCAN_CNT_EN
        check("tbl_cnt", out_cnt8, tbl[e].empty ? 0 : tbl[e].nbeats - b);
`endif
        tick();
      end
      out_ready8 = 1'b0;
      check("tbl_done_valid", out_valid8, 0);
      check("tbl_done_ready", in_ready8, 1);
    end

    // All-ones with out_ready toggling: 8 beats, held while stalled
    scan8(8'hFF, 1, "toggle_ff");

    // Reset in the middle of a scan
    in_data8 = 8'b11000111; in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    check("mid_idx7", out_idx8, 7);
    tick();
    check("mid_idx6", out_idx8, 6);
    tick();
    check("mid_idx2", out_idx8, 2);
    check("mid_valid", out_valid8, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid8, 0);
    check("mid_rst_ready", in_ready8, 1);
    check("mid_rst_idx", out_idx8, 0);
    check("mid_rst_last", out_last8, 0);
    tick();
    rst = 1'b0;
    out_ready8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("post_rst_no_beat", out_valid8, 0);
      tick();
    end
    scan8(8'b00000100, 0, "after_rst");

    // Random vectors, random backpressure, in_valid noise during scans
    for (int r = 0; r < 40; r++) scan8(8'($urandom), 2, "rand");

    // N=16: back-to-back acceptance with in_valid held high
    in_data16 = 16'h8001; in_valid16 = 1'b1; out_ready16 = 1'b1;
    tick();
    in_data16 = 16'h0010;
    check("n16_b0_valid", out_valid16, 1);
    check("n16_b0_idx", out_idx16, 15);
    check("n16_b0_last", out_last16, 0);
    tick();
    check("n16_b1_idx", out_idx16, 0);
    check("n16_b1_last", out_last16, 1);
    tick();
    check("n16_gap_valid", out_valid16, 0);
    check("n16_gap_ready", in_ready16, 1);
    tick();
    in_valid16 = 1'b0;
    check("n16_second_valid", out_valid16, 1);
    check("n16_second_idx", out_idx16, 4);
    check("n16_second_last", out_last16, 1);
`ifdef PRIO_SCAN_CNT_EN
    check("n16_second_cnt", out_cnt16, 1);
`endif
    tick();
    check("n16_done_ready", in_ready16, 1);
    out_ready16 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
